history_register: RTL and testbench

Parametrised successor to the plain enable-loaded data register. It holds a WIDTH-bit value that can be loaded, counted, shifted or rotated under a 3-bit opcode. Every value-changing operation first pushes the previous value onto a DEPTH-entry circular history, so later operations can be undone. It sits wherever datapath state needs both arithmetic or shift updates and single-step rollback, for example score, position or entry registers.

---
 rtl/history_register_if.sv | 32 +++
 rtl/history_register.sv | 154 +++++++++++++++
 tb/tb_history_register.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/history_register_if.sv
// history_register_if
// Groups the operation request and the register status of history_register.
//   master : drives enable, op, din, serial_in; observes the status outputs
//   slave  : the register itself; observes the request and drives
//            dout, carry, zero, history_count, undo_err
// Clock and reset are not part of the bundle.
interface history_register_if #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             enable;
    logic [2:0]       op;
    logic [WIDTH-1:0] din;
    logic             serial_in;
    logic [WIDTH-1:0] dout;
    logic             carry;
    logic             zero;
    logic [CW-1:0]    history_count;
    logic             undo_err;

    modport master (
        output enable, op, din, serial_in,
        input  dout, carry, zero, history_count, undo_err
    );

    modport slave (
        input  enable, op, din, serial_in,
        output dout, carry, zero, history_count, undo_err
    );
endinterface

// File: rtl/history_register.sv
// history_register
// WIDTH-bit register that can be loaded, incremented, decremented, shifted
// or rotated under a 3-bit opcode. Every value-changing operation first
// saves the old value in a DEPTH-entry circular history, so UNDO can roll
// the register back one step at a time.
// Ports:
//   clock    : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : history_register_if slave modport
//              (enable, op, din, serial_in in; dout, carry, zero,
//               history_count, undo_err out)
module history_register #(
    parameter int               WIDTH       = 7,
    parameter int               DEPTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input logic               clock,
    input logic               reset_n,
    history_register_if.slave bus
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_SLOT  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_LOAD = 3'b001,
        OP_INC  = 3'b010,
        OP_DEC  = 3'b011,
        OP_SHL  = 3'b100,
        OP_SHR  = 3'b101,
        OP_ROL  = 3'b110,
        OP_UNDO = 3'b111
    } op_e;

    op_e              op_code;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] next_data;
    logic             carry_q;
    logic             next_carry;
    logic [CW-1:0]    count;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    ptr_fwd;
    logic [PW-1:0]    ptr_back;
    logic             undo_err_q;
    logic             push;
    logic             pop;
    logic             fail;
    logic [WIDTH-1:0] history [DEPTH];

    assign op_code = op_e'(bus.op);

    // Pointer neighbours, wrapping modulo DEPTH (DEPTH need not be a power of two).
    always_comb begin
        ptr_fwd  = (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + PW'(1);
        ptr_back = (wr_ptr == '0) ? LAST_SLOT : wr_ptr - PW'(1);
    end

    // Next register value and carry, plus whether this cycle pushes, pops
    // or reports an UNDO on an empty history.
    always_comb begin
        next_data  = data;
        next_carry = carry_q;
        push       = 1'b0;
        pop        = 1'b0;
        fail       = 1'b0;
        if (bus.enable) begin
            case (op_code)
                OP_LOAD: begin
                    next_data  = bus.din;
                    next_carry = 1'b0;
                    push       = 1'b1;
                end
                OP_INC: begin
                    {next_carry, next_data} = {1'b0, data} + {{WIDTH{1'b0}}, 1'b1};
                    push = 1'b1;
                end
                OP_DEC: begin
                    next_data  = data - {{(WIDTH-1){1'b0}}, 1'b1};
                    next_carry = (data == '0);
                    push       = 1'b1;
                end
                OP_SHL: begin
                    next_data  = {data[WIDTH-2:0], bus.serial_in};
                    next_carry = data[WIDTH-1];
                    push       = 1'b1;
                end
                OP_SHR: begin
                    next_data  = {bus.serial_in, data[WIDTH-1:1]};
                    next_carry = data[0];
                    push       = 1'b1;
                end
                OP_ROL: begin
                    next_data  = {data[WIDTH-2:0], data[WIDTH-1]};
                    next_carry = data[WIDTH-1];
                    push       = 1'b1;
                end
                OP_UNDO: begin
                    // An empty history leaves data and carry untouched.
                    if (count != '0) begin
                        next_data  = history[ptr_back];
                        next_carry = 1'b0;
                        pop        = 1'b1;
                    end else begin
                        fail = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Register state, history bookkeeping and the error pulse. Once the
    // history is full the pointer keeps advancing, so the oldest slot is
    // overwritten while the count stays saturated.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data       <= RESET_VALUE;
            carry_q    <= 1'b0;
            count      <= '0;
            wr_ptr     <= '0;
            undo_err_q <= 1'b0;
        end else begin
            data       <= next_data;
            carry_q    <= next_carry;
            undo_err_q <= fail;
            if (push) begin
                wr_ptr <= ptr_fwd;
                if (count != FULL_COUNT) begin
                    count <= count + CW'(1);
                end
            end else if (pop) begin
                wr_ptr <= ptr_back;
                count  <= count - CW'(1);
            end
        end
    end

    // History storage carries no reset; only entries below count are ever read.
    always_ff @(posedge clock) begin
        if (push) begin
            history[wr_ptr] <= data;
        end
    end

    assign bus.dout          = data;
    assign bus.carry         = carry_q;
    assign bus.zero          = (data == '0);
    assign bus.history_count = count;
    assign bus.undo_err      = undo_err_q;

endmodule

// File: tb/tb_history_register.sv
// tb_history_register
// Directed stimulus for history_register (WIDTH=7, DEPTH=4, RESET_VALUE=0).
// Each stimulus step queues its hand-computed expected outputs together
// with the cycle at which they become visible; an independent monitor pops
// and compares them on falling edges.
module tb_history_register;

    localparam int WIDTH = 7;
    localparam int DEPTH = 4;

    localparam logic [2:0] HOLD = 3'b000;
    localparam logic [2:0] LOAD = 3'b001;
    localparam logic [2:0] INC  = 3'b010;
    localparam logic [2:0] DEC  = 3'b011;
    localparam logic [2:0] SHL  = 3'b100;
    localparam logic [2:0] SHR  = 3'b101;
    localparam logic [2:0] ROL  = 3'b110;
    localparam logic [2:0] UNDO = 3'b111;

    typedef struct {
        int               due;
        logic [WIDTH-1:0] dout;
        logic             carry;
        logic             zero;
        logic [2:0]       count;
        logic             err;
        string            name;
    } expect_t;

    logic    clock   = 1'b0;
    logic    reset_n = 1'b0;
    int      cyc     = 0;
    int      compared   = 0;
    int      mismatched = 0;
    expect_t sb[$];

    always #5 clock = ~clock;

    history_register_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    history_register #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .RESET_VALUE(7'd0)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus)
    );

    // Cycle counter used to time-stamp when each expectation becomes due.
    always @(posedge clock) cyc <= cyc + 1;

    function automatic void compareField(string name, string field,
                                         logic [31:0] actual, logic [31:0] required);
        compared++;
        if (actual !== required) begin
            mismatched++;
            $display("[TB] FAIL %s.%s: got %0h, required %0h", name, field, actual, required);
        end
    endfunction

    // Monitor: pops every expectation whose cycle has arrived and compares
    // it with what the DUT presents, away from the rising edge.
    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            expect_t e;
            e = sb.pop_front();
            compareField(e.name, "dout",          32'(bus.dout),          32'(e.dout));
            compareField(e.name, "carry",         32'(bus.carry),         32'(e.carry));
            compareField(e.name, "zero",          32'(bus.zero),          32'(e.zero));
            compareField(e.name, "history_count", 32'(bus.history_count), 32'(e.count));
            compareField(e.name, "undo_err",      32'(bus.undo_err),      32'(e.err));
        end
    end

    function automatic void pushExpect(int due, logic [WIDTH-1:0] d, logic c,
                                       logic [2:0] n, logic err, string name);
        expect_t e;
        e.due   = due;
        e.dout  = d;
        e.carry = c;
        e.zero  = (d == '0);
        e.count = n;
        e.err   = err;
        e.name  = name;
        sb.push_back(e);
    endfunction

    // Drive one op on a falling edge; its result is due after the next rising edge.
    task automatic applyStimulus(input logic en, input logic [2:0] op,
                                 input logic [WIDTH-1:0] d, input logic si,
                                 input logic [WIDTH-1:0] exp_dout, input logic exp_carry,
                                 input logic [2:0] exp_count, input logic exp_err,
                                 input string name);
        @(negedge clock);
        bus.enable    = en;
        bus.op        = op;
        bus.din       = d;
        bus.serial_in = si;
        pushExpect(cyc + 1, exp_dout, exp_carry, exp_count, exp_err, name);
        @(posedge clock);
    endtask

    // Expectation on the current state, checked before the next rising edge.
    task automatic checkOutput(input logic [WIDTH-1:0] exp_dout, input logic exp_carry,
                               input logic [2:0] exp_count, input string name);
        pushExpect(cyc, exp_dout, exp_carry, exp_count, 1'b0, name);
    endtask

    // Assert reset a little after a rising edge and check that it clears
    // the outputs before the following edge.
    task automatic resetMidCycle(input string name);
        @(negedge clock);
        bus.enable = 1'b0;
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        checkOutput(7'h00, 1'b0, 3'd0, name);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        bus.enable    = 1'b0;
        bus.op        = HOLD;
        bus.din       = '0;
        bus.serial_in = 1'b0;
        reset_n       = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput(7'h00, 1'b0, 3'd0, "reset");
        @(negedge clock);
        reset_n = 1'b1;

        // Empty-history UNDO and the one-cycle error pulse
        applyStimulus(1, UNDO, 7'h00, 0, 7'h00, 0, 3'd0, 1, "undo_empty");
        applyStimulus(1, HOLD, 7'h00, 0, 7'h00, 0, 3'd0, 0, "err_clears");

        // LOAD and INC wrap
        applyStimulus(1, LOAD, 7'h7E, 0, 7'h7E, 0, 3'd1, 0, "load_7e");
        applyStimulus(1, INC,  7'h00, 0, 7'h7F, 0, 3'd2, 0, "inc_7f");
        applyStimulus(1, INC,  7'h00, 0, 7'h00, 1, 3'd3, 0, "inc_wrap");

        // DEC borrow and undo
        applyStimulus(1, LOAD, 7'h00, 0, 7'h00, 0, 3'd4, 0, "load_0");
        applyStimulus(1, DEC,  7'h00, 0, 7'h7F, 1, 3'd4, 0, "dec_borrow");
        applyStimulus(1, UNDO, 7'h00, 0, 7'h00, 0, 3'd3, 0, "undo_dec");

        // Shifts and rotate
        applyStimulus(1, LOAD, 7'h41, 0, 7'h41, 0, 3'd4, 0, "load_41");
        applyStimulus(1, SHL,  7'h00, 0, 7'h02, 1, 3'd4, 0, "shl");
        applyStimulus(1, SHR,  7'h00, 1, 7'h41, 0, 3'd4, 0, "shr");
        applyStimulus(1, ROL,  7'h00, 0, 7'h03, 1, 3'd4, 0, "rol");

        resetMidCycle("reset_clear");

        // History overflow: only the newest four old values survive
        applyStimulus(1, LOAD, 7'h01, 0, 7'h01, 0, 3'd1, 0, "ovf_load1");
        applyStimulus(1, LOAD, 7'h02, 0, 7'h02, 0, 3'd2, 0, "ovf_load2");
        applyStimulus(1, LOAD, 7'h03, 0, 7'h03, 0, 3'd3, 0, "ovf_load3");
        applyStimulus(1, LOAD, 7'h04, 0, 7'h04, 0, 3'd4, 0, "ovf_load4");
        applyStimulus(1, LOAD, 7'h05, 0, 7'h05, 0, 3'd4, 0, "ovf_load5");
        applyStimulus(1, LOAD, 7'h06, 0, 7'h06, 0, 3'd4, 0, "ovf_load6");
        applyStimulus(1, UNDO, 7'h00, 0, 7'h05, 0, 3'd3, 0, "ovf_undo1");
        applyStimulus(1, UNDO, 7'h00, 0, 7'h04, 0, 3'd2, 0, "ovf_undo2");
        applyStimulus(1, UNDO, 7'h00, 0, 7'h03, 0, 3'd1, 0, "ovf_undo3");
        applyStimulus(1, UNDO, 7'h00, 0, 7'h02, 0, 3'd0, 0, "ovf_undo4");
        applyStimulus(1, UNDO, 7'h00, 0, 7'h02, 0, 3'd0, 1, "ovf_undo5");

        // Enable gating
        applyStimulus(0, LOAD, 7'h55, 0, 7'h02, 0, 3'd0, 0, "gate_1");
        applyStimulus(0, LOAD, 7'h55, 0, 7'h02, 0, 3'd0, 0, "gate_2");
        applyStimulus(0, UNDO, 7'h55, 0, 7'h02, 0, 3'd0, 0, "gate_3");

        // Three pushes, asynchronous reset, then UNDO on the lost history
        applyStimulus(1, LOAD, 7'h10, 0, 7'h10, 0, 3'd1, 0, "pre_load");
        applyStimulus(1, INC,  7'h00, 0, 7'h11, 0, 3'd2, 0, "pre_inc1");
        applyStimulus(1, INC,  7'h00, 0, 7'h12, 0, 3'd3, 0, "pre_inc2");
        resetMidCycle("reset_mid");
        applyStimulus(1, UNDO, 7'h00, 0, 7'h00, 0, 3'd0, 1, "undo_after_reset");

        // Push right after UNDO reuses the vacated slot
        applyStimulus(1, LOAD, 7'h05, 0, 7'h05, 0, 3'd1, 0, "reuse_load5");
        applyStimulus(1, LOAD, 7'h06, 0, 7'h06, 0, 3'd2, 0, "reuse_load6");
        applyStimulus(1, UNDO, 7'h00, 0, 7'h05, 0, 3'd1, 0, "reuse_undo1");
        applyStimulus(1, LOAD, 7'h07, 0, 7'h07, 0, 3'd2, 0, "reuse_load7");
        applyStimulus(1, UNDO, 7'h00, 0, 7'h05, 0, 3'd1, 0, "reuse_undo2");
        applyStimulus(1, UNDO, 7'h00, 0, 7'h00, 0, 3'd0, 0, "reuse_undo3");
        applyStimulus(1, LOAD, 7'h00, 0, 7'h00, 0, 3'd1, 0, "load_same");

        @(negedge clock);
        bus.enable = 1'b0;
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clock);
        while (sb.size() > 0) begin
            expect_t e;
            e = sb.pop_front();
            compared++;
            mismatched++;
            $display("[TB] FAIL %s.drain: got unchecked, required checked", e.name);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
